// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - multi-cycle branch/jump resolution sharing one adder
// A request runs compare and target passes through the same adder, then waits for fetch to take it.
module branch_resolve_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] pc_plus1,
  input  logic [WIDTH-1:0] imm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic             err,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_TGT  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BNE = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             err_q, err_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             resp_hs;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             eq;
  logic             cond;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign resp_hs = resp_ready && (state_q == S_RESP);

  // The only adder: rs - rt during CMP, pc_plus1 + imm otherwise.
  always_comb begin
    add_a   = pc_q;
    add_b   = imm_q;
    add_cin = 1'b0;
    if (state_q == S_CMP) begin
      add_a   = rs_q;
      add_b   = ~rt_q;
      add_cin = 1'b1;
    end
  end

  assign add_sum = add_a + add_b + WIDTH'(add_cin);
  assign eq      = (add_sum == '0);
  assign cond    = (op_q == OP_BEQ) ? eq : !eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_BEQ, OP_BNE: state_d = S_CMP;
            OP_J:           state_d = S_TGT;
            default:        state_d = S_RESP;
          endcase
        end
      end
      S_CMP:   state_d = cond ? S_TGT : S_RESP;
      S_TGT:   state_d = S_RESP;
      S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
    taken      = (state_q == S_RESP) && taken_q;
    err        = (state_q == S_RESP) && err_q;
    target     = (state_q == S_RESP) ? target_q : '0;
    flush      = flush_q;
    taken_cnt  = cnt_q;
  end

  always_comb begin
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    taken_d  = taken_q;
    target_d = target_q;
    err_d    = err_q;
    if (accept) begin
      op_d     = req_op;
      rs_d     = rs_val;
      rt_d     = rt_val;
      pc_d     = pc_plus1;
      imm_d    = imm;
      taken_d  = 1'b0;
      target_d = '0;
      err_d    = (req_op == 2'b11);
    end
    if (state_q == S_CMP && !cond) begin
      taken_d  = 1'b0;
      target_d = '0;
    end
    if (state_q == S_TGT) begin
      taken_d  = 1'b1;
      target_d = (op_q == OP_J) ? imm_q : add_sum;
    end
  end

  // Flush and the counter both follow a taken handshake by one edge.
  always_comb begin
    flush_d = resp_hs && taken_q;
    cnt_d   = cnt_q;
    if (resp_hs && taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      err_q    <= 1'b0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      err_q    <= err_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Multi-cycle branch resolution controller for the 16-bit MIPS core.
- Accepts one branch/jump request at a time from decode and time-shares a single internal 16-bit adder:
  - first pass: equality compare, rs + ~rt + 1;
  - second pass: target computation, pc_plus1 + imm.
- Returns taken/target to the fetch stage over a valid/ready handshake.
- Raises a one-cycle flush when a taken branch is consumed.

Parameters:
- WIDTH, 16, datapath width of operands, PC and target.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  decode presents a request
- req_ready  output  1  controller can accept a request
- req_op  input  2  00 BEQ, 01 BNE, 10 J, 11 reserved
- rs_val  input  WIDTH  first compare operand
- rt_val  input  WIDTH  second compare operand
- pc_plus1  input  WIDTH  address of the instruction after the branch
- imm  input  WIDTH  sign-extended offset (BEQ/BNE) or absolute target (J)
- resp_valid  output  1  result available
- resp_ready  input  1  fetch consumes the result
- taken  output  1  branch/jump is taken
- target  output  WIDTH  next PC when taken; 0 when not taken
- err  output  1  reserved opcode flagged
- flush  output  1  one-cycle pulse on the consumption of a taken response
- busy  output  1  high in every state except IDLE
- taken_cnt  output  CNT_W  saturating count of taken responses consumed

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; req_ready=1; all other outputs 0. Internal operand registers are cleared.
- Reset mid-operation: an in-flight request is discarded with no response.
- Acceptance and FSM states:
  - A request is accepted on a clk edge with req_valid & req_ready. req_ready is 1 only in IDLE.
  - Operands and op are registered at acceptance; input changes afterwards are ignored.
  - IDLE: on accept, BEQ/BNE -> CMP, J -> TGT, reserved -> RESP with err=1, taken=0, target=0.
  - CMP: adder computes rs + ~rt + 1 (modulo 2^WIDTH); eq = (difference == 0); carry-out is ignored. cond = eq for BEQ, !eq for BNE. cond=1 -> TGT; cond=0 -> RESP with taken=0, target=0.
  - TGT: BEQ/BNE target = pc_plus1 + imm, truncated to WIDTH (wrap-around, no overflow flag); J target = imm, no adder pass. taken=1 -> RESP.
  - RESP: resp_valid=1. taken, target and err are held stable until resp_valid & resp_ready, then -> IDLE.
- Latency from the accept edge to resp_valid:
  - taken BEQ/BNE: 3 cycles;
  - not-taken BEQ/BNE: 2 cycles;
  - J: 2 cycles;
  - reserved: 1 cycle.
- Response completion:
  - resp_valid drops on the cycle after the handshake.
  - Next accept is possible on the cycle after returning to IDLE. Throughput is 1 request per latency + 1 cycles minimum.
  - flush is a registered pulse, high for exactly the one cycle after a handshake with taken=1; it is never asserted for not-taken or err responses.
  - taken_cnt increments by 1 in the same cycle as flush and saturates at 2^CNT_W − 1 (no wrap).
- resp_ready held low: the controller stalls in RESP indefinitely; req_ready stays 0.
- resp_ready high on entry to RESP: handshake completes in the first RESP cycle.
- Adder usage: exactly one adder instance, with operands muxed by state; no second adder or comparator.

Test Plan:
- BEQ rs=0x1234, rt=0x1234, pc_plus1=0x0010, imm=0x0005 -> resp_valid 3 cycles after accept, taken=1, target=0x0015; flush pulse 1 cycle after the handshake; taken_cnt=1.
- BNE rs=0x1234, rt=0x1234 -> resp_valid after 2 cycles, taken=0, target=0, no flush; then BEQ rs=0x0000, rt=0xFFFF -> taken=0 (carry-out does not affect equality).
- BEQ equal operands, pc_plus1=0xFFFE, imm=0x0004 -> target=0x0002 (wrap). imm=0xFFFC with pc_plus1=0x0002 -> target=0xFFFE (negative offset).
- J imm=0xABCD with resp_ready held low 5 cycles -> resp_valid, taken=1 and target=0xABCD held stable all 5 cycles; req_ready=0 throughout; flush only after the handshake.
- req_op=11 -> resp_valid 1 cycle after accept with err=1, taken=0, no flush. Back-to-back requests: req_valid held high is accepted only when req_ready=1.
- Assert rst during CMP and during RESP -> next cycle state is IDLE, req_ready=1, resp_valid=0, taken_cnt=0, and no stale response appears afterwards. Force taken_cnt to saturation with CNT_W=2: after 4 taken responses it holds at 3.
